key_input_pio: RTL

- Avalon-MM slave input port for the DE2-115 push-buttons/switches; the input-direction counterpart of the LED output PIO in the same Qsys system.
- Synchronises and optionally debounces external pins, and exposes the live level to the CPU.
- Latches edges away from the idle level into a capture register and raises a maskable level interrupt to the Nios II.

---
 rtl/key_input_pio.sv | 114 +++++++++++
 1 files changed

// File: rtl/key_input_pio.sv
// Avalon-MM input PIO: synchronises push-button/switch pins, latches edges away from idle, raises a maskable IRQ.
// Optional per-bit debounce filter enabled by defining KEY_INPUT_PIO_DEBOUNCE_EN.
module key_input_pio #(
   parameter int unsigned WIDTH           = 4,
   parameter bit          IDLE_LEVEL      = 1'b1,
   parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic             irq
);

   localparam logic [WIDTH-1:0] IDLE_VEC = {WIDTH{IDLE_LEVEL}};

   logic [WIDTH-1:0] r_sync1;
   logic [WIDTH-1:0] r_sync2;
   logic [WIDTH-1:0] r_prev;
   logic [WIDTH-1:0] r_mask;
   logic [WIDTH-1:0] r_cap;

   logic [WIDTH-1:0] w_stable;
   logic [WIDTH-1:0] w_edge;
   logic [WIDTH-1:0] w_wdata;
   logic [WIDTH-1:0] w_clr;
   logic             w_wr;
   logic             w_unused;

   assign w_wr    = chipselect & ~write_n;
   assign w_wdata = writedata[WIDTH-1:0];
   assign w_clr   = (w_wr && (address == 2'd3)) ? w_wdata : '0;

   // Two-flop synchroniser for the asynchronous pins.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync1 <= IDLE_VEC;
         r_sync2 <= IDLE_VEC;
      end else begin
         r_sync1 <= in_port;
         r_sync2 <= r_sync1;
      end
   end

`ifdef KEY_INPUT_PIO_DEBOUNCE_EN
   localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0]            r_stable;
   logic [WIDTH-1:0][CNT_W-1:0] r_cnt;

   // A bit only follows sync2 after it has disagreed for DEBOUNCE_CYCLES consecutive cycles.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_stable <= IDLE_VEC;
         r_cnt    <= '0;
      end else begin
         for (int i = 0; i < int'(WIDTH); i++) begin
            if (r_sync2[i] != r_stable[i]) begin
               if (r_cnt[i] == CNT_LAST) begin
                  r_stable[i] <= r_sync2[i];
                  r_cnt[i]    <= '0;
               end else begin
                  r_cnt[i] <= r_cnt[i] + CNT_W'(1);
               end
            end else begin
               r_cnt[i] <= '0;
            end
         end
      end
   end

   assign w_stable = r_stable;
   assign w_unused = ^writedata;
`else
   assign w_stable = r_sync2;
   // Upper write-data bits, and the debounce length when filtering is off, are ignored.
   assign w_unused = ^{writedata, 32'(DEBOUNCE_CYCLES)};
`endif

   assign w_edge = ~(r_prev ^ IDLE_VEC) & (w_stable ^ IDLE_VEC);

   // Edge capture (set beats clear on the same bit), interrupt mask and previous-level history.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_prev <= IDLE_VEC;
         r_mask <= '0;
         r_cap  <= '0;
      end else begin
         r_prev <= w_stable;
         r_cap  <= (r_cap & ~w_clr) | w_edge;
         if (w_wr && (address == 2'd2)) begin
            r_mask <= w_wdata;
         end
      end
   end

   always_comb begin
      readdata = '0;
      case (address)
         2'd0:    readdata = 32'(w_stable);
         2'd2:    readdata = 32'(r_mask);
         2'd3:    readdata = 32'(r_cap);
         default: readdata = '0;
      endcase
   end

   assign irq = |(r_cap & r_mask);

endmodule
